iir_pole: RTL
=============

# iir_pole

Recursive (pole) half of the 2nd-order IIR filter, placed directly after the 12-bit-input, 21-bit-output zero section. The zero section supplies the feed-forward sum in Q10 coefficient scale. This block subtracts the two feedback products, rescales and saturates to a 12-bit output, and keeps the output history. It uses one shared 12x12 multiplier under a 4-state FSM, so it accepts at most one sample every 4 clocks.

## Interface
- DIN_W, 21: width of feed-forward input (signed, Q10-scaled)
- DOUT_W, 12: output sample width (signed)
- COE_W, 12: feedback coefficient width (signed)
- Q_SHIFT, 10: coefficient fractional bits (1.0 = 1024)
- A1, -1957: feedback coefficient a1 (~ -1.911)
- A2, 937: feedback coefficient a2 (~ 0.915)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high (all state cleared while high)
- Xin  in  DIN_W  signed feed-forward sum from zero section
- in_valid  in  1  Xin valid; accepted only when in_ready=1
- in_ready  out  1  block idle, can accept a sample
- Yout  out  DOUT_W  signed filtered output, held between updates
- out_valid  out  1  one-cycle pulse, Yout updated
- sat  out  1  one-cycle pulse with out_valid, set when this sample was clipped
- overrun  out  1  sticky; set when in_valid is high while in_ready is low

## Operation
- Recurrence: y[n] = sat( (x[n] - A1*y[n-1] - A2*y[n-2]) >>> Q_SHIFT ).
- y1 and y2 hold the history. Both are reset to 0 and always store the saturated value.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid: acc <= sign-extended Xin, go to MAC1.
  - MAC1: acc <= acc - A1*y1, go to MAC2.
  - MAC2: acc <= acc - A2*y2, go to DONE.
  - DONE: Yout <= sat(acc>>>Q_SHIFT); y2 <= y1; y1 <= new Yout; out_valid=1; sat set if clipped; go to IDLE.
- Widths:
  - Product: COE_W+DOUT_W = 24 bits.
  - Accumulator: 25 bits signed, never overflows for legal inputs.
  - Shift: arithmetic, floor (truncation toward -inf).
  - Saturation clamps to [-2048, 2047].
- Multiplier: single instance; MAC1 and MAC2 select its operand (A1/y1 or A2/y2).
- Busy input: in_valid while in_ready=0 is dropped. Yout and history are unaffected, and overrun is set until reset.
- Reset mid-operation: the in-flight sample is discarded with no out_valid. State returns to IDLE with acc, y1, y2, Yout=0.

## Timing
- Reset values: Yout=0, out_valid=0, sat=0, overrun=0, in_ready=1, state IDLE.
- Latency: sample accepted at edge k gives out_valid high in the cycle after edge k+3, with Yout valid in that same cycle.
- Throughput: 1 sample per 4 clocks. in_ready is high again in the cycle after DONE.
- in_ready is combinational from state (IDLE); all other outputs are registered.
- in_valid in the same cycle that DONE returns to IDLE is not accepted (in_ready still 0) and counts as overrun.

## Configuration
- IIR_POLE_ROUND_EN:
  - Defined: add 2^(Q_SHIFT-1)=512 to acc before the shift, giving round-half-up.
  - Undefined: plain arithmetic shift (floor).
- Saturation and all other behaviour are identical either way.

## Structure
- Shared package iir_pkg holds:
  - width constants DIN_W, DOUT_W, COE_W, Q_SHIFT
  - default coefficients A1, A2 (alongside the zero-section coefficients)
  - FSM state enum {IDLE, MAC1, MAC2, DONE}
- Sub-module iir_sat: combinational shift (+ optional round) and clamp from 25 bits to DOUT_W, outputs value and clip flag. Shared with future sections.

## Test plan
- Reset: hold rst_n high 3 clocks -> Yout=0, out_valid=0, sat=0, overrun=0, in_ready=1.
- Impulse, macro off: Xin=1024, then 0,0,0, each on idle -> Yout sequence 1, 1, 0, -1. out_valid exactly 4 clocks after each accept.
- Impulse, IIR_POLE_ROUND_EN: same stimulus -> Yout 1, 2, 3.
- Saturation: from reset, Xin=1000000 twice -> Yout 976 (sat=0), then 2047 (sat=1; raw 2841). y1 stored as 2047.
- Overrun: in_valid pulse with Xin=5000 one clock after an accept -> ignored, overrun=1 and stays 1. Next out_valid reflects only the first sample.
- Reset mid-op: assert rst_n during MAC2 -> no out_valid, Yout=0. A subsequent Xin=1024 impulse yields 1 again.

Source files
------------

// File: rtl/iir_pkg.sv
// iir_pkg: widths, default coefficients and FSM states shared by the IIR filter sections.
`default_nettype none

package iir_pkg;

    localparam int DIN_W   = 21;
    localparam int DOUT_W  = 12;
    localparam int COE_W   = 12;
    localparam int Q_SHIFT = 10;
    localparam int PROD_W  = COE_W + DOUT_W;
    localparam int ACC_W   = PROD_W + 1;

    // Feedback (pole) coefficients, Q10: a1 ~ -1.911, a2 ~ 0.915
    localparam logic signed [COE_W-1:0] A1 = -12'sd1957;
    localparam logic signed [COE_W-1:0] A2 = 12'sd937;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC1 = 2'd1,
        MAC2 = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/iir_sat.sv
// iir_sat: arithmetic down-shift (optionally rounded, IIR_POLE_ROUND_EN) and clamp to OUT_W bits.
`default_nettype none

module iir_sat #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 12,
    parameter int SHIFT = 10
) (
    input  logic [IN_W-1:0]  acc,
    output logic [OUT_W-1:0] value,
    output logic             clip
);

    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((2**(OUT_W-1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(-(2**(OUT_W-1)));

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        // One guard bit so the rounding bias can never wrap
        biased = $signed({acc[IN_W-1], acc});
`ifdef IIR_POLE_ROUND_EN
        biased = biased + $signed(EXT_W'(2**(SHIFT-1)));
`endif
        shifted = biased >>> SHIFT;
        clip    = 1'b0;
        value   = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            clip  = 1'b1;
            value = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            clip  = 1'b1;
            value = MIN_V[OUT_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/iir_pole.sv
// iir_pole: recursive half of the 2nd-order IIR, one shared multiplier, one sample per 4 clocks.
// Optional round-half-up before the shift when IIR_POLE_ROUND_EN is defined.
`default_nettype none

module iir_pole
    import iir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIN_W-1:0]  Xin,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DOUT_W-1:0] Yout,
    output logic              out_valid,
    output logic              sat,
    output logic              overrun
);

    state_t state;
    state_t next_state;

    logic signed [ACC_W-1:0]  acc;
    logic signed [DOUT_W-1:0] y1;
    logic signed [DOUT_W-1:0] y2;

    logic signed [COE_W-1:0]  coef;
    logic signed [DOUT_W-1:0] hist;
    logic signed [PROD_W-1:0] prod;

    logic [DOUT_W-1:0] sat_value;
    logic              sat_clip;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = MAC1;
            MAC1:    next_state = MAC2;
            MAC2:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Single multiplier; operands follow the MAC step in progress
    always_comb begin
        coef = A1;
        hist = y1;
        if (state == MAC2) begin
            coef = A2;
            hist = y2;
        end
        prod = coef * hist;
    end

    iir_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DOUT_W),
        .SHIFT (Q_SHIFT)
    ) u_sat (
        .acc   (acc),
        .value (sat_value),
        .clip  (sat_clip)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc       <= '0;
            y1        <= '0;
            y2        <= '0;
            Yout      <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sat       <= 1'b0;
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: if (in_valid) acc <= ACC_W'($signed(Xin));
                MAC1: acc <= acc - ACC_W'(prod);
                MAC2: acc <= acc - ACC_W'(prod);
                DONE: begin
                    Yout      <= sat_value;
                    y2        <= y1;
                    y1        <= $signed(sat_value);
                    out_valid <= 1'b1;
                    sat       <= sat_clip;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
